grf_wb_driver: RTL and testbench

Write-back driver for the general register file: the initiator side of the GRF write port (RegWrite/RegAddr/RegData/PC). It merges retire writes from the main pipeline with results from the long-latency multiply/divide unit, buffers the latter in a small FIFO, and drives exactly one registered write per cycle. It also reports whether a decode-stage source register has a write still in flight, so the hazard unit can stall.

---
 rtl/grf_wb_driver.sv | 129 ++++++++++++
 tb/tb_grf_wb_driver.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/grf_wb_driver.sv
// Write-back driver for the GRF write port: merges pipeline retire writes with
// buffered multiply/divide results and issues one registered write per cycle.
module grf_wb_driver #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic [31:0] pipe_pc,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    input  logic [31:0] md_pc,
    output logic        RegWrite,
    output logic [4:0]  RegAddr,
    output logic [31:0] RegData,
    output logic [31:0] PC,
    input  logic [4:0]  chk_a1,
    input  logic [4:0]  chk_a2,
    output logic        pend1,
    output logic        pend2,
    output logic        stall_req
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    // Handshake: an md entry transfers on a rising edge where md_valid && md_ready;
    // pipe_valid has no ready and must be held low by upstream while stall_req is high.

    logic [4:0]    q_addr [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [31:0]   q_pc   [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;

    logic          full, empty, push, pop;
    logic          sel_we;
    logic [4:0]    sel_addr;
    logic [31:0]   sel_data, sel_pc;
    logic          hit1, hit2;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign md_ready  = !full && !reset;
    assign push      = md_valid && md_ready && (md_addr != 5'd0);
    assign stall_req = (starve_cnt == SW'(STARVE_MAX));

    // A starving FIFO wins over the pipe; otherwise the pipe wins and the FIFO
    // fills any slot the pipe leaves free (including writes to $0).
    always_comb begin
        pop      = 1'b0;
        sel_we   = 1'b0;
        sel_addr = pipe_addr;
        sel_data = pipe_data;
        sel_pc   = pipe_pc;
        if (stall_req && !empty) begin
            pop = 1'b1;
        end else if (pipe_valid && (pipe_addr != 5'd0) && !stall_req) begin
            sel_we = 1'b1;
        end else if (!empty) begin
            pop = 1'b1;
        end
        if (pop) begin
            sel_we   = 1'b1;
            sel_addr = q_addr[rd_ptr];
            sel_data = q_data[rd_ptr];
            sel_pc   = q_pc[rd_ptr];
        end
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                if (q_addr[rd_ptr + AW'(i)] == chk_a1) hit1 = 1'b1;
                if (q_addr[rd_ptr + AW'(i)] == chk_a2) hit2 = 1'b1;
            end
        end
    end

    assign pend1 = (chk_a1 != 5'd0) && (hit1 || (RegWrite && (RegAddr == chk_a1)));
    assign pend2 = (chk_a2 != 5'd0) && (hit2 || (RegWrite && (RegAddr == chk_a2)));

    // Storage needs no reset: entries are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= md_addr;
            q_data[wr_ptr] <= md_data;
            q_pc[wr_ptr]   <= md_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            RegWrite   <= 1'b0;
            RegAddr    <= 5'd0;
            RegData    <= 32'd0;
            PC         <= 32'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);

            if (pop || empty)  starve_cnt <= '0;
            else if (!stall_req) starve_cnt <= starve_cnt + SW'(1);

            RegWrite <= sel_we;
            if (sel_we) begin
                RegAddr <= sel_addr;
                RegData <= sel_data;
                PC      <= sel_pc;
            end
        end
    end

endmodule

// File: tb/tb_grf_wb_driver.sv
// Directed bench for grf_wb_driver: a vector table for the basic write paths
// plus hand-written sequences for starvation, FIFO wrap and mid-run reset.
module tb_grf_wb_driver;

    typedef struct {
        logic        rst;
        logic        pv;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic [31:0] ppc;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic [31:0] mpc;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic        e_we;
        logic        e_chk;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] e_pc;
        logic        e_rdy;
        logic        e_stall;
        logic        e_p1;
        logic        e_p2;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_valid;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data, pipe_pc;
    logic        md_valid, md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data, md_pc;
    logic        RegWrite;
    logic [4:0]  RegAddr;
    logic [31:0] RegData, PC;
    logic [4:0]  chk_a1, chk_a2;
    logic        pend1, pend2, stall_req;

    int n_vec  = 0;
    int n_miss = 0;
    string cur_tag;

    always #5 clk = ~clk;

    grf_wb_driver #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .pipe_valid(pipe_valid), .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_pc(pipe_pc),
        .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data), .md_pc(md_pc),
        .RegWrite(RegWrite), .RegAddr(RegAddr), .RegData(RegData), .PC(PC),
        .chk_a1(chk_a1), .chk_a2(chk_a2), .pend1(pend1), .pend2(pend2), .stall_req(stall_req)
    );

    task automatic check_field(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL %s %s: got %h want %h", cur_tag, nm, act, exp);
            n_miss++;
        end
    endtask

    // Drive one vector, clock once, then compare against its expected outputs.
    task automatic apply(input string tag, input vec_t v);
        cur_tag = tag;
        if (v.pv && !v.rst && stall_req) begin
            $display("FAIL %s protocol: pipe_valid driven while stall_req=%0b", tag, stall_req);
            n_miss++;
        end
        reset = v.rst; pipe_valid = v.pv; pipe_addr = v.pa; pipe_data = v.pd; pipe_pc = v.ppc;
        md_valid = v.mv; md_addr = v.ma; md_data = v.md; md_pc = v.mpc;
        chk_a1 = v.c1; chk_a2 = v.c2;
        @(posedge clk);
        #1;
        n_vec++;
        check_field("RegWrite", 32'(RegWrite), 32'(v.e_we));
        if (v.e_chk) begin
            check_field("RegAddr", 32'(RegAddr), 32'(v.e_addr));
            check_field("RegData", RegData, v.e_data);
            check_field("PC", PC, v.e_pc);
        end
        check_field("md_ready", 32'(md_ready), 32'(v.e_rdy));
        check_field("stall_req", 32'(stall_req), 32'(v.e_stall));
        check_field("pend1", 32'(pend1), 32'(v.e_p1));
        check_field("pend2", 32'(pend2), 32'(v.e_p2));
    endtask

    vec_t tbl[12];
    vec_t v;

    initial begin
        //            rst pv pa  pd       ppc       mv ma md       mpc      c1 c2  we chk addr data    pc       rdy stl p1 p2
        tbl[0]  = '{1, 0, 0, 0,       0,        0, 0, 0,       0,       0, 0,  0, 1, 0, 0,       0,       0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0,       0,        0, 0, 0,       0,       0, 0,  0, 1, 0, 0,       0,       1, 0, 0, 0};
        tbl[2]  = '{0, 1, 5, 'h1234,  'h3000,   0, 0, 0,       0,       5, 0,  1, 1, 5, 'h1234,  'h3000,  1, 0, 1, 0};
        tbl[3]  = '{0, 0, 0, 0,       0,        0, 0, 0,       0,       5, 0,  0, 1, 5, 'h1234,  'h3000,  1, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0,       0,        1, 8, 'hA,     'h100,   8, 9,  0, 0, 0, 0,       0,       1, 0, 1, 0};
        tbl[5]  = '{0, 0, 0, 0,       0,        1, 9, 'hB,     'h104,   8, 9,  1, 1, 8, 'hA,     'h100,   1, 0, 1, 1};
        tbl[6]  = '{0, 0, 0, 0,       0,        0, 0, 0,       0,       8, 9,  1, 1, 9, 'hB,     'h104,   1, 0, 0, 1};
        tbl[7]  = '{0, 0, 0, 0,       0,        0, 0, 0,       0,       8, 9,  0, 1, 9, 'hB,     'h104,   1, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0,       0,        1, 0, 'hDEAD,  'h200,   0, 0,  0, 0, 0, 0,       0,       1, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0,       0,        1, 3, 'h33,    'h204,   3, 0,  0, 0, 0, 0,       0,       1, 0, 1, 0};
        tbl[10] = '{0, 1, 0, 'h77,    'h208,    0, 0, 0,       0,       3, 0,  1, 1, 3, 'h33,    'h204,   1, 0, 1, 0};
        tbl[11] = '{0, 0, 0, 0,       0,        0, 0, 0,       0,       3, 0,  0, 1, 3, 'h33,    'h204,   1, 0, 0, 0};

        reset = 1'b1; pipe_valid = 1'b0; pipe_addr = '0; pipe_data = '0; pipe_pc = '0;
        md_valid = 1'b0; md_addr = '0; md_data = '0; md_pc = '0; chk_a1 = '0; chk_a2 = '0;

        for (int i = 0; i < 12; i++) apply($sformatf("tbl%0d", i), tbl[i]);

        // Starvation: pipe busy every cycle while four md results queue up.
        for (int i = 1; i <= 9; i++) begin
            v = '{0, 1, 5'(i), 32'('h1000 + i), 32'('h4000 + 4 * i),
                  (i <= 4), 5'(19 + i), 32'('h20 + i - 1), 32'('h500 + 4 * (i - 1)),
                  20, 0, 1, 1, 5'(i), 32'('h1000 + i), 32'('h4000 + 4 * i),
                  (i < 4), (i == 9), 1, 0};
            apply($sformatf("starve%0d", i), v);
        end
        apply("starve_pop", '{0, 0, 0, 0, 0, 0, 0, 0, 0, 20, 21, 1, 1, 20, 'h20, 'h500, 1, 0, 1, 1});

        // Fill to full with a wrapped write pointer, then push+pop together.
        apply("wrapA", '{0, 1, 10, 'h10A, 'h600, 1, 24, 'h24, 'h510, 24, 0,  1, 1, 10, 'h10A, 'h600, 0, 0, 1, 0});
        apply("wrapB", '{0, 0, 0,  0,     0,     1, 25, 'h25, 'h514, 25, 21, 1, 1, 21, 'h21,  'h504, 1, 0, 0, 1});
        apply("wrapC", '{0, 0, 0,  0,     0,     1, 25, 'h25, 'h514, 25, 22, 1, 1, 22, 'h22,  'h508, 1, 0, 1, 1});
        apply("wrapD", '{0, 0, 0,  0,     0,     0, 0,  0,    0,     25, 23, 1, 1, 23, 'h23,  'h50C, 1, 0, 1, 1});
        apply("wrapE", '{0, 0, 0,  0,     0,     0, 0,  0,    0,     25, 24, 1, 1, 24, 'h24,  'h510, 1, 0, 1, 1});
        apply("wrapF", '{0, 0, 0,  0,     0,     0, 0,  0,    0,     25, 24, 1, 1, 25, 'h25,  'h514, 1, 0, 1, 0});
        apply("wrapG", '{0, 0, 0,  0,     0,     0, 0,  0,    0,     25, 0,  0, 1, 25, 'h25,  'h514, 1, 0, 0, 0});

        // Reset with three queued entries and a live write on the port.
        apply("rstR1", '{0, 1, 11, 'h111, 'h700, 1, 26, 'h26, 'h520, 26, 0,  1, 1, 11, 'h111, 'h700, 1, 0, 1, 0});
        apply("rstR2", '{0, 1, 12, 'h112, 'h704, 1, 27, 'h27, 'h524, 26, 0,  1, 1, 12, 'h112, 'h704, 1, 0, 1, 0});
        apply("rstR3", '{0, 1, 13, 'h113, 'h708, 1, 28, 'h28, 'h528, 26, 13, 1, 1, 13, 'h113, 'h708, 1, 0, 1, 1});
        apply("rstR4", '{1, 0, 0,  0,     0,     0, 0,  0,    0,     26, 13, 0, 1, 0,  0,     0,     0, 0, 0, 0});
        apply("rstR5", '{0, 0, 0,  0,     0,     0, 0,  0,    0,     26, 27, 0, 1, 0,  0,     0,     1, 0, 0, 0});
        apply("rstR6", '{0, 0, 0,  0,     0,     0, 0,  0,    0,     26, 27, 0, 1, 0,  0,     0,     1, 0, 0, 0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
